// File: rtl/block_data_mem.sv
// block_data_mem: multi-cycle backing store for the lab data cache.
// Serves aligned block reads of BLOCK_WORDS words and single-word byte-masked
// writes. Every access takes LATENCY clock edges from acceptance to commit.
// Completion is signalled by a one-cycle ready pulse.
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous reset, active-high (memory contents survive it)
//   MemRead   read request, sampled only while idle
//   MemWrite  write request, sampled only while idle; wins over MemRead
//   addr      word address
//   data_in   write data
//   byte_en   write byte mask, bit i covers data_in[8i+7:8i]
//   data_out  read block, word at the block base address in the MSBs
//   ready     one-cycle completion pulse
//   busy      high while an access is in flight
module block_data_mem #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned BLOCK_WORDS = 4,
    parameter int unsigned LATENCY     = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          MemRead,
    input  logic                          MemWrite,
    input  logic [ADDR_W-1:0]             addr,
    input  logic [DATA_W-1:0]             data_in,
    input  logic [DATA_W/8-1:0]           byte_en,
    output logic [DATA_W*BLOCK_WORDS-1:0] data_out,
    output logic                          ready,
    output logic                          busy
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned BE_W  = DATA_W / 8;
    localparam int unsigned OUT_W = DATA_W * BLOCK_WORDS;
    localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [ADDR_W-1:0] BLK_MASK = ADDR_W'(BLOCK_WORDS - 1);

    typedef enum logic {StIdle, StWait} state_t;
    typedef logic [DATA_W-1:0] mem_t [DEPTH];

    function automatic int unsigned image_word(input int unsigned idx);
        unique case (idx)
            0:       return 17;
            1:       return 9;
            2:       return 25;
            default: return 17;
        endcase
    endfunction

    // Power-up image: words 0..3 seeded, the rest zero; seeds past DEPTH dropped.
    function automatic mem_t init_image();
        mem_t img;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            img[i] = '0;
        end
        for (int unsigned i = 0; i < 4; i++) begin
            if (i < DEPTH) begin
                img[ADDR_W'(i)] = DATA_W'(image_word(i));
            end
        end
        return img;
    endfunction

    mem_t r_mem = init_image();

    state_t              r_state;
    state_t              w_state_next;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_next;
    logic                r_is_write;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [BE_W-1:0]     r_be;
    logic                r_ready;
    logic                r_busy;
    logic [OUT_W-1:0]    r_data_out;
    logic                w_accept;
    logic                w_complete;
    logic [ADDR_W-1:0]   w_base;
    logic [OUT_W-1:0]    w_block;

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_accept     = 1'b0;
        w_complete   = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (MemWrite || MemRead) begin
                    w_accept     = 1'b1;
                    w_cnt_next   = CNT_W'(LATENCY - 1);
                    w_state_next = StWait;
                end
            end
            StWait: begin
                if (r_cnt != '0) begin
                    w_cnt_next = r_cnt - CNT_W'(1);
                end else begin
                    w_complete   = 1'b1;
                    w_state_next = StIdle;
                end
            end
        endcase
    end

    // Block is aligned, so base + k never carries out of ADDR_W bits.
    assign w_base = r_addr & ~BLK_MASK;

    always_comb begin
        w_block = '0;
        for (int unsigned k = 0; k < BLOCK_WORDS; k++) begin
            w_block[(BLOCK_WORDS - 1 - k) * DATA_W +: DATA_W] = r_mem[w_base + ADDR_W'(k)];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= StIdle;
            r_cnt      <= '0;
            r_is_write <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_be       <= '0;
            r_ready    <= 1'b0;
            r_busy     <= 1'b0;
            r_data_out <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_ready <= w_complete;
            if (w_accept) begin
                r_busy     <= 1'b1;
                r_is_write <= MemWrite;
                r_addr     <= addr;
                r_wdata    <= data_in;
                r_be       <= byte_en;
            end
            if (w_complete) begin
                r_busy <= 1'b0;
                if (!r_is_write) begin
                    r_data_out <= w_block;
                end
            end
        end
    end

    // Storage has no reset; an aborted write never reaches the completing edge.
    always_ff @(posedge clk) begin
        if (w_complete && r_is_write && !rst) begin
            for (int unsigned b = 0; b < BE_W; b++) begin
                if (r_be[b]) begin
                    r_mem[r_addr][8 * b +: 8] <= r_wdata[8 * b +: 8];
                end
            end
        end
    end

    assign data_out = r_data_out;
    assign ready    = r_ready;
    assign busy     = r_busy;

endmodule

// File: tb/tb_block_data_mem.sv
module tb_block_data_mem;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_bad  = 0;
    int n_done = 0;

    for (genvar g = 0; g < 3; g++) begin : g_cfg
        localparam int unsigned DW    = (g == 0) ? 32 : 64;
        localparam int unsigned AW    = (g == 0) ? 10 : ((g == 1) ? 6 : 4);
        localparam int unsigned BW    = (g == 0) ? 4 : ((g == 1) ? 8 : 1);
        localparam int unsigned LAT   = (g == 0) ? 3 : ((g == 1) ? 7 : 1);
        localparam int unsigned DEPTH = 2 ** AW;
        localparam int unsigned OW    = DW * BW;
        localparam int unsigned BEW   = DW / 8;

        logic           rst;
        logic           rd;
        logic           wr;
        logic [AW-1:0]  a;
        logic [DW-1:0]  din;
        logic [BEW-1:0] be;
        logic [OW-1:0]  dout;
        logic           rdy;
        logic           bsy;

        block_data_mem #(
            .DATA_W      (DW),
            .ADDR_W      (AW),
            .BLOCK_WORDS (BW),
            .LATENCY     (LAT)
        ) u_dut (
            .clk      (clk),
            .rst      (rst),
            .MemRead  (rd),
            .MemWrite (wr),
            .addr     (a),
            .data_in  (din),
            .byte_en  (be),
            .data_out (dout),
            .ready    (rdy),
            .busy     (bsy)
        );

        // Transaction-level model: an access accepted at edge n commits at edge n+LAT.
        logic [DW-1:0]  m_mem [DEPTH];
        logic [OW-1:0]  m_dout;
        bit             m_rdy;
        bit             m_bsy;
        bit             m_act;
        bit             m_wr;
        int             m_edge;
        int             m_done;
        logic [AW-1:0]  m_a;
        logic [DW-1:0]  m_d;
        logic [BEW-1:0] m_be;
        bit             go_dir;
        bit             dir_done;

        task automatic chk(input string name, input logic [OW-1:0] act,
                           input logic [OW-1:0] exp);
            n_cmp++;
            if (act !== exp) begin
                n_bad++;
                $display("FAIL cfg%0d %s edge %0d: got %0h want %0h", g, name, m_edge, act, exp);
            end
        endtask

        task automatic chk_int(input string name, input int act, input int exp);
            n_cmp++;
            if (act != exp) begin
                n_bad++;
                $display("FAIL cfg%0d %s: got %0d want %0d", g, name, act, exp);
            end
        endtask

        task automatic model_reset();
            m_act  = 0;
            m_rdy  = 0;
            m_bsy  = 0;
            m_dout = '0;
        endtask

        task automatic model_edge(input bit r, input bit w, input int ad,
                                  input logic [DW-1:0] d, input logic [BEW-1:0] b);
            int base;
            m_edge++;
            m_rdy = 0;
            if (m_act && m_edge == m_done) begin
                if (m_wr) begin
                    for (int i = 0; i < int'(BEW); i++) begin
                        if (m_be[i]) m_mem[m_a][8 * i +: 8] = m_d[8 * i +: 8];
                    end
                end else begin
                    base = (int'(m_a) / int'(BW)) * int'(BW);
                    for (int k = 0; k < int'(BW); k++) begin
                        m_dout[int'(OW) - int'(DW) * (k + 1) +: DW] = m_mem[base + k];
                    end
                end
                m_rdy = 1;
                m_bsy = 0;
                m_act = 0;
            end else if (!m_act && (r || w)) begin
                m_act  = 1;
                m_wr   = w;
                m_a    = AW'(ad);
                m_d    = d;
                m_be   = b;
                m_done = m_edge + int'(LAT);
                m_bsy  = 1;
            end
        endtask

        task automatic compare();
            chk("ready", OW'(rdy), OW'(m_rdy));
            chk("busy", OW'(bsy), OW'(m_bsy));
            chk("data_out", dout, m_dout);
        endtask

        // Called at a falling edge: drive, advance model, then check at the next falling edge.
        task automatic step(input bit r, input bit w, input int ad,
                            input logic [DW-1:0] d, input logic [BEW-1:0] b);
            rd  = r;
            wr  = w;
            a   = AW'(ad);
            din = d;
            be  = b;
            model_edge(r, w, ad, d, b);
            @(negedge clk);
            compare();
        endtask

        task automatic idle(input int n);
            for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, '0, '0);
        endtask

        function automatic logic [DW-1:0] rand_word();
            logic [DW-1:0] w;
            for (int i = 0; i < int'(BEW); i++) w[8 * i +: 8] = 8'($urandom_range(255));
            return w;
        endfunction

        if (g == 0) begin : g_dir
            initial begin
                wait (go_dir);
                chk("rst_ready", OW'(rdy), '0);
                chk("rst_busy", OW'(bsy), '0);
                chk("rst_data", dout, '0);
                // Read of the seeded block through addr 2.
                step(1'b1, 1'b0, 2, '0, '0);
                idle(1);
                chk("rr_busy_e1", OW'(bsy), OW'(1));
                chk("rr_ready_e1", OW'(rdy), '0);
                idle(1);
                chk("rr_busy_e2", OW'(bsy), OW'(1));
                chk("rr_ready_e2", OW'(rdy), '0);
                idle(1);
                chk("rr_ready_e3", OW'(rdy), OW'(1));
                chk("rr_data", dout, OW'(128'h00000011_00000009_00000019_00000011));
                idle(1);
                chk("rr_ready_drop", OW'(rdy), '0);
                // Byte-masked write, then read its block.
                step(1'b0, 1'b1, 5, 32'hAABBCCDD, 4'b0101);
                idle(3);
                chk("bw_ready", OW'(rdy), OW'(1));
                step(1'b1, 1'b0, 4, '0, '0);
                idle(3);
                chk("bw_data", dout, OW'(128'h00000000_00BB00DD_00000000_00000000));
                // Both requests: write only; MemRead during WAIT ignored.
                step(1'b1, 1'b1, 0, 32'h12345678, 4'hF);
                step(1'b1, 1'b0, 0, '0, '0);
                idle(2);
                chk("sim_ready", OW'(rdy), OW'(1));
                chk("sim_data_kept", dout, OW'(128'h00000000_00BB00DD_00000000_00000000));
                idle(1);
                chk("sim_no_extra", OW'(rdy), '0);
                step(1'b1, 1'b0, 0, '0, '0);
                idle(3);
                chk("sim_readback", dout, OW'(128'h12345678_00000009_00000019_00000011));
                // Reset in the middle of a write.
                step(1'b0, 1'b1, 8, 32'hFFFFFFFF, 4'hF);
                idle(1);
                #2 rst = 1'b1;
                #1;
                chk("ar_ready", OW'(rdy), '0);
                chk("ar_busy", OW'(bsy), '0);
                chk("ar_data", dout, '0);
                model_reset();
                @(negedge clk);
                rst = 1'b0;
                compare();
                step(1'b1, 1'b0, 8, '0, '0);
                idle(3);
                chk("ar_ready_rd", OW'(rdy), OW'(1));
                chk("ar_no_write", dout, '0);
                dir_done = 1;
            end
        end else begin : g_nodir
            initial begin
                wait (go_dir);
                dir_done = 1;
            end
        end

        initial begin : main
            int q[$];
            int ad;
            int sel;
            int win;
            for (int i = 0; i < int'(DEPTH); i++) m_mem[i] = '0;
            for (int i = 0; i < 4 && i < int'(DEPTH); i++) begin
                m_mem[i] = DW'((i == 0) ? 17 : (i == 1) ? 9 : (i == 2) ? 25 : 17);
            end
            m_edge = 0;
            m_done = 0;
            model_reset();
            rst = 1'b1;
            rd  = 1'b0;
            wr  = 1'b0;
            a   = '0;
            din = '0;
            be  = '0;
            @(negedge clk);
            @(negedge clk);
            rst = 1'b0;
            compare();
            go_dir = 1;
            wait (dir_done);

            // Held read: pulses must land every LAT+1 edges, first after LAT.
            for (int i = 1; i <= 3 * (int'(LAT) + 1); i++) begin
                step(1'b1, 1'b0, int'($urandom_range(DEPTH - 1)), '0, '0);
                if (rdy) q.push_back(i);
            end
            chk_int("b2b_count", q.size(), 3);
            for (int k = 0; k < q.size(); k++) chk_int("b2b_edge", q[k], (k + 1) * (int'(LAT) + 1));

            // Top block, read through its last address.
            step(1'b0, 1'b1, int'(DEPTH - BW), rand_word(), '1);
            idle(int'(LAT));
            step(1'b0, 1'b1, int'(DEPTH - 1), rand_word(), '1);
            idle(int'(LAT));
            step(1'b1, 1'b0, int'(DEPTH - 1), '0, '0);
            idle(int'(LAT));

            win = (DEPTH > 16) ? 16 : int'(DEPTH);
            for (int i = 0; i < 400; i++) begin
                sel = int'($urandom_range(3));
                if (sel == 0) ad = int'($urandom_range(win - 1));
                else if (sel == 1) ad = int'(DEPTH) - 1 - int'($urandom_range(win - 1));
                else ad = int'($urandom_range(DEPTH - 1));
                step($urandom_range(3) == 0, $urandom_range(4) == 0, ad, rand_word(),
                     BEW'($urandom));
            end
            idle(int'(LAT) + 1);
            n_done++;
        end
    end

    initial begin
        for (int c = 0; c < 20000; c++) begin
            @(negedge clk);
            if (n_done == 3) break;
        end
        n_cmp++;
        if (n_done != 3) begin
            n_bad++;
            $display("FAIL timeout: configs done %0d want 3", n_done);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
